pipemem_mmio: RTL and testbench
===============================

# pipemem_mmio

Parametrised data-memory stage for the pipelined CPU's MEM stage. It replaces the word-only RAM/IO split with three additions: byte/halfword/word loads and stores with sign or zero extension, a registered one-cycle read-response handshake, and misalignment detection. Addresses with bit `IO_BIT` set decode to a small register bank holding a synchronised input port, an output latch, a change-detect flag and a free-running cycle timer; all other addresses go to an on-chip word RAM.

## Interface
Parameters:
- `RAM_AW`, 5: RAM word-address width. Depth is 2^RAM_AW words, indexed by `addr[RAM_AW+1:2]`.
- `IO_BIT`, 7: address bit that selects IO space (1) or RAM (0). Must be greater than `RAM_AW+1`.
- `IN_W`, 10: width of `io_in`.
- `OUT_W`, 28: width of `io_out`.

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req`, in, 1: access request, valid this cycle.
- `we`, in, 1: 1 = store, 0 = load. Qualified by `req`.
- `size`, in, 2: access size. 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `sign_ext`, in, 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `addr`, in, 32: byte address.
- `datain`, in, 32: store data, right-aligned.
- `dataout`, out, 32: load result, right-aligned and extended.
- `rvalid`, out, 1: response strobe, one cycle after `req`.
- `err`, out, 1: misaligned access, valid with `rvalid`.
- `io_in`, in, IN_W: asynchronous external inputs.
- `io_out`, out, OUT_W: output latch.

## Operation
- Alignment:
  - half requires `addr[0]=0`; word requires `addr[1:0]=0`.
  - A misaligned request performs no write and no side effect (no flag clear, no timer load).
  - Its response is `err=1`, `dataout=0`.
- Stores:
  - byte writes `datain[7:0]` into lane `addr[1:0]`.
  - half writes `datain[15:0]` into lanes {`addr[1]`*2, +1}.
  - word writes all four lanes.
  - Per-byte write enables; the other lanes are unchanged.
- Loads:
  - The selected lane(s) are extracted from the addressed word and right-aligned.
  - Bits above the lane are filled with the lane MSB if `sign_ext`, else 0.
- RAM addresses alias modulo depth: bits between `RAM_AW+2` and `IO_BIT-1` are ignored.
- IO word index = `addr[4:2]`:
  - 0, `io_out` latch: R/W with byte enables. Only bits [OUT_W-1:0] are stored; the upper bits read 0.
  - 1, `in_sync`: read-only. `io_in` after a 2-flop synchroniser, zero-extended. Writes are ignored.
  - 2, `timer`: 32-bit up-counter, +1 every cycle, wraps from 0xFFFFFFFF to 0. A store loads the merged write data.
  - 3, `chg`: bit 0 is set when `in_sync` differs from its previous-cycle value. An aligned load of index 3 clears it. Stores are ignored.
  - 4–7: read 0, writes ignored.
- Simultaneous events:
  - Timer store and increment in the same cycle: the stored value wins; counting resumes from it on the next cycle.
  - `chg` set and read-clear in the same cycle: set wins; the read returns the pre-edge value.
- `req=0`: no access, `rvalid=0` next cycle, `dataout` holds its last value.

## Timing
- Reset (asynchronous, immediate):
  - `dataout=0`, `rvalid=0`, `err=0`, `io_out=0`, `timer=0`, `chg=0`, synchroniser flops 0.
  - RAM contents are not reset.
- Request in cycle N:
  - RAM/IO write commits at the rising edge ending cycle N.
  - `rvalid`, `err` and `dataout` are registered and valid throughout cycle N+1.
  - `rvalid` is a single-cycle pulse per request; back-to-back requests give back-to-back strobes.
  - A store also pulses `rvalid`, with `dataout=0`.
- Read-after-write to the same word in consecutive cycles returns the new data (no bypass needed, because the write commits before the read in N+1 is sampled).
- `io_in` to `in_sync` latency: 2 cycles. `chg` sets 3 cycles after an `io_in` edge.
- `io_out` changes at the edge that commits the store.
- `reset` asserted mid-request: the response is suppressed and the write is not guaranteed; the bench must not check RAM contents for that cycle.

## Test plan
- Store word 0x8000_00F0 at 0x10, then load byte at 0x13 with `sign_ext=1` → `dataout=0xFFFF_FF80`. The same load with `sign_ext=0` → `0x0000_0080`.
- Store byte 0xAB at 0x21 over an existing word 0x1122_3344, then load word → `0x1122_AB44`, `rvalid` exactly one cycle after each `req`.
- Load half at 0x05 → `err=1`, `dataout=0`. Then store word at 0x0A → `err=1`, and a subsequent word load at 0x08 shows the old data unchanged.
- Store 0x0FFF_FFFF to IO index 0 (addr 0x80) → `io_out=0xFFF_FFFF`. Store 0xFFFF_FFFF → `io_out` still 0xFFF_FFFF, and the readback returns 0x0FFF_FFFF.
- Toggle `io_in` from 0 to 0x2A5 → `in_sync` reads 0x2A5 from the 3rd cycle after the edge, and `chg` reads 1. A second read of `chg` returns 0. An edge coinciding with the `chg` read leaves `chg=1`.
- Store 0xFFFF_FFFE to the timer (addr 0x88), then read it on consecutive cycles → 0xFFFF_FFFF, then 0x0000_0000 (wrap). Assert `reset` mid-run → `timer`, `io_out`, `rvalid` and `dataout` are all 0 immediately.

Source files
------------

// File: rtl/pipemem_mmio_if.sv
// pipemem_mmio_if: MEM-stage request/response bundle.
// The master drives the request and the slave returns a registered response.
interface pipemem_mmio_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        rvalid;
  logic        err;

  modport master (
    output req, we, size, sign_ext, addr, datain,
    input  dataout, rvalid, err
  );

  modport slave (
    input  req, we, size, sign_ext, addr, datain,
    output dataout, rvalid, err
  );
endinterface

// File: rtl/pipemem_mmio.sv
// pipemem_mmio: byte/half/word data memory with an MMIO register bank.
// Responses are registered one cycle after the request.
module pipemem_mmio #(
  parameter int RAM_AW = 5,
  parameter int IO_BIT = 7,
  parameter int IN_W   = 10,
  parameter int OUT_W  = 28
) (
  input  logic             clock,
  input  logic             reset,
  pipemem_mmio_if.slave    bus,
  input  logic [IN_W-1:0]  io_in,
  output logic [OUT_W-1:0] io_out
);

  localparam int DEPTH = 1 << RAM_AW;

  logic [31:0]       ram [DEPTH];
  logic [IN_W-1:0]   sync1;
  logic [IN_W-1:0]   in_sync;
  logic [IN_W-1:0]   in_prev;
  logic [31:0]       timer;
  logic              chg;

  logic              aligned;
  logic              ok;
  logic              is_io;
  logic [2:0]        idx;
  logic [RAM_AW-1:0] widx;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rword;
  logic [31:0]       lane;
  logic [31:0]       ldata;
  logic [31:0]       out_w;
  logic [31:0]       in_w;
  logic [31:0]       out_new;
  logic [31:0]       tmr_new;
  logic              ram_we;
  logic              out_we;
  logic              tmr_we;
  logic              chg_clr;
  logic              chg_set;
  logic              unused_bits;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  en
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (en[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  assign idx   = bus.addr[4:2];
  assign widx  = bus.addr[RAM_AW+1:2];
  assign is_io = bus.addr[IO_BIT];
  assign out_w = {{(32-OUT_W){1'b0}}, io_out};
  assign in_w  = {{(32-IN_W){1'b0}}, in_sync};

  always_comb begin
    aligned = 1'b1;
    be      = 4'b1111;
    wdata   = bus.datain;
    unique case (bus.size)
      2'b00: begin
        be    = 4'b0001 << bus.addr[1:0];
        wdata = {4{bus.datain[7:0]}};
      end
      2'b01: begin
        aligned = ~bus.addr[0];
        be      = 4'b0011 << {bus.addr[1], 1'b0};
        wdata   = {2{bus.datain[15:0]}};
      end
      default: aligned = (bus.addr[1:0] == 2'b00);
    endcase
  end

  // Misaligned requests are fully squashed: no writes, no read side effects.
  assign ok      = bus.req & aligned;
  assign ram_we  = ok & bus.we & ~is_io;
  assign out_we  = ok & bus.we & is_io & (idx == 3'd0);
  assign tmr_we  = ok & bus.we & is_io & (idx == 3'd2);
  assign chg_clr = ok & ~bus.we & is_io & (idx == 3'd3);
  assign chg_set = (in_sync != in_prev);

  assign out_new = merge(out_w, wdata, be);
  assign tmr_new = merge(timer, wdata, be);

  always_comb begin
    rword = ram[widx];
    if (is_io) begin
      case (idx)
        3'd0:    rword = out_w;
        3'd1:    rword = in_w;
        3'd2:    rword = timer;
        3'd3:    rword = {31'b0, chg};
        default: rword = 32'b0;
      endcase
    end
  end

  assign lane = rword >> {bus.addr[1:0], 3'b000};

  always_comb begin
    ldata = lane;
    unique case (bus.size)
      2'b00:   ldata = {{24{bus.sign_ext & lane[7]}}, lane[7:0]};
      2'b01:   ldata = {{16{bus.sign_ext & lane[15]}}, lane[15:0]};
      default: ldata = lane;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.rvalid  <= 1'b0;
      bus.err     <= 1'b0;
      bus.dataout <= 32'b0;
    end else begin
      bus.rvalid <= bus.req;
      bus.err    <= bus.req & ~aligned;
      if (bus.req)
        bus.dataout <= (aligned & ~bus.we) ? ldata : 32'b0;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      in_sync <= '0;
      in_prev <= '0;
      io_out  <= '0;
      timer   <= 32'b0;
      chg     <= 1'b0;
    end else begin
      sync1   <= io_in;
      in_sync <= sync1;
      in_prev <= in_sync;
      if (out_we) io_out <= out_new[OUT_W-1:0];
      timer <= tmr_we ? tmr_new : timer + 32'd1;
      if (chg_set)      chg <= 1'b1;
      else if (chg_clr) chg <= 1'b0;
    end
  end

  assign unused_bits = ^{bus.addr, out_new};

endmodule

// File: tb/tb_pipemem_mmio.sv
// tb_pipemem_mmio: directed scoreboard bench for pipemem_mmio.
// Expected responses are queued at drive time and popped on rvalid.
module tb_pipemem_mmio;

  logic        clock;
  logic        reset;
  logic [9:0]  io_in;
  logic [27:0] io_out;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  pipemem_mmio_if bus();

  pipemem_mmio #(
    .RAM_AW(5), .IO_BIT(7), .IN_W(10), .OUT_W(28)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .io_in (io_in),
    .io_out(io_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a,
                       input logic [31:0] d, input logic x_err,
                       input logic [31:0] x_data);
    exp_t n;
    bus.req      = 1'b1;
    bus.we       = w;
    bus.size     = sz;
    bus.sign_ext = sx;
    bus.addr     = a;
    bus.datain   = d;
    n.due  = cyc + 1;
    n.err  = x_err;
    n.data = x_data;
    sb.push_back(n);
  endtask

  task automatic op(input logic w, input logic [1:0] sz,
                    input logic sx, input logic [31:0] a,
                    input logic [31:0] d, input logic x_err,
                    input logic [31:0] x_data);
    @(posedge clock); #1;
    drive(w, sz, sx, a, d, x_err, x_data);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      bus.req = 1'b0;
    end
  endtask

  task automatic set_in(input logic [9:0] v);
    @(posedge clock); #1;
    bus.req = 1'b0;
    io_in   = v;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("rvalid", {31'b0, bus.rvalid}, 32'd1);
        chk("err", {31'b0, bus.err}, {31'b0, e.err});
        chk("dataout", bus.dataout, e.data);
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        chk("resp_late", 32'(e.due), 32'(cyc));
      end else begin
        chk("rvalid_idle", {31'b0, bus.rvalid}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  initial begin
    reset        = 1'b1;
    bus.req      = 1'b0;
    bus.we       = 1'b0;
    bus.size     = 2'b00;
    bus.sign_ext = 1'b0;
    bus.addr     = 32'b0;
    bus.datain   = 32'b0;
    io_in        = 10'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_dataout", bus.dataout, 32'h0);
    chk("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    chk("rst_err", {31'b0, bus.err}, 32'h0);
    chk("rst_io_out", {4'b0, io_out}, 32'h0);
    reset = 1'b0;

    op(1, W, 0, 32'h10, 32'h8000_00F0, 0, 32'h0);
    op(0, B, 1, 32'h13, 32'h0, 0, 32'hFFFF_FF80);
    op(0, B, 0, 32'h13, 32'h0, 0, 32'h0000_0080);
    op(1, W, 0, 32'h20, 32'h1122_3344, 0, 32'h0);
    op(1, B, 0, 32'h21, 32'h0000_00AB, 0, 32'h0);
    op(0, W, 0, 32'h20, 32'h0, 0, 32'h1122_AB44);
    op(1, W, 0, 32'h08, 32'hCAFE_BABE, 0, 32'h0);
    op(0, H, 1, 32'h05, 32'h0, 1, 32'h0);
    op(1, W, 0, 32'h0A, 32'h1234_5678, 1, 32'h0);
    op(0, W, 0, 32'h08, 32'h0, 0, 32'hCAFE_BABE);
    op(0, H, 1, 32'h0A, 32'h0, 0, 32'hFFFF_CAFE);
    op(0, H, 0, 32'h08, 32'h0, 0, 32'h0000_BABE);
    op(0, B, 1, 32'h09, 32'h0, 0, 32'hFFFF_FFBA);
    op(0, W, 0, 32'h108, 32'h0, 0, 32'hCAFE_BABE);
    op(0, 2'b11, 0, 32'h08, 32'h0, 0, 32'hCAFE_BABE);
    gap(1);

    op(1, W, 0, 32'h80, 32'h0FFF_FFFF, 0, 32'h0);
    gap(1); #2;
    chk("io_out_a", {4'b0, io_out}, 32'h0FFF_FFFF);
    op(1, W, 0, 32'h80, 32'hFFFF_FFFF, 0, 32'h0);
    gap(1); #2;
    chk("io_out_b", {4'b0, io_out}, 32'h0FFF_FFFF);
    op(0, W, 0, 32'h80, 32'h0, 0, 32'h0FFF_FFFF);
    op(1, B, 0, 32'h81, 32'h0, 0, 32'h0);
    gap(1); #2;
    chk("io_out_byte", {4'b0, io_out}, 32'h0FFF_00FF);
    op(0, H, 1, 32'h82, 32'h0, 0, 32'h0000_0FFF);
    op(1, W, 0, 32'h81, 32'h0, 1, 32'h0);
    gap(1); #2;
    chk("io_out_mis", {4'b0, io_out}, 32'h0FFF_00FF);

    op(0, W, 0, 32'h8C, 32'h0, 0, 32'h0);
    set_in(10'h2A5);
    op(0, W, 0, 32'h84, 32'h0, 0, 32'h0);
    op(0, W, 0, 32'h84, 32'h0, 0, 32'h0000_02A5);
    op(0, W, 0, 32'h8C, 32'h0, 0, 32'h1);
    op(0, W, 0, 32'h8C, 32'h0, 0, 32'h0);
    op(1, W, 0, 32'h84, 32'hFFFF_FFFF, 0, 32'h0);
    op(0, W, 0, 32'h84, 32'h0, 0, 32'h0000_02A5);
    op(1, W, 0, 32'h8C, 32'h1, 0, 32'h0);
    op(0, W, 0, 32'h8C, 32'h0, 0, 32'h0);
    op(0, W, 0, 32'h94, 32'h0, 0, 32'h0);

    set_in(10'h15A);
    gap(1);
    op(0, W, 0, 32'h8C, 32'h0, 0, 32'h0);
    op(0, W, 0, 32'h8E, 32'h0, 1, 32'h0);
    op(0, B, 0, 32'h8C, 32'h0, 0, 32'h1);
    op(0, W, 0, 32'h8C, 32'h0, 0, 32'h0);

    op(1, W, 0, 32'h88, 32'hFFFF_FFFE, 0, 32'h0);
    gap(1);
    op(0, W, 0, 32'h88, 32'h0, 0, 32'hFFFF_FFFF);
    op(0, W, 0, 32'h88, 32'h0, 0, 32'h0000_0000);

    op(0, W, 0, 32'h80, 32'h0, 0, 32'h0FFF_00FF);
    @(posedge clock); #3;
    reset   = 1'b1;
    bus.req = 1'b0;
    sb.delete();
    #1;
    chk("mid_rvalid", {31'b0, bus.rvalid}, 32'h0);
    chk("mid_dataout", bus.dataout, 32'h0);
    chk("mid_io_out", {4'b0, io_out}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    drive(0, W, 0, 32'h88, 32'h0, 0, 32'h0);
    op(0, W, 0, 32'h88, 32'h0, 0, 32'h1);
    op(0, W, 0, 32'h80, 32'h0, 0, 32'h0);
    op(0, W, 0, 32'h20, 32'h0, 0, 32'h1122_AB44);
    gap(2);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
